data_mem_lsu: RTL and testbench
===============================

# data_mem_lsu

Parametrised successor to the core's word-only data memory. It accepts byte-addressed load/store requests over a valid/ready handshake and performs byte/halfword/word lane steering, byte-enable generation and load sign/zero extension internally. Storage is a register array of configurable depth, and read latency is configurable. It detects misaligned, reserved-size and out-of-range accesses, and returns exactly one in-order response per request. It sits between the MEM stage and storage, replacing the word-aligned memory plus external lane logic.

## Interface
Parameters:
- DEPTH_WORDS, 4096: number of 32-bit words; any value ≥ 2, not necessarily a power of two.
- READ_LATENCY, 1: accept-to-response latency in cycles; legal range 1..4.
- IDX_W, $clog2(DEPTH_WORDS): word-index width. Derived; do not override.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, LSB-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- rsp_err  out  1  request was faulted.

## Operation
- Accept: a request is accepted when req_valid && req_ready at a rising edge.
- Handshake rule: req_ready = !stall, where stall = last_stage_valid && !rsp_ready. It is combinational and does not depend on req_valid.
- Word index: req_addr[31:2].
- Fault conditions (rsp_err = 1):
  - req_size == 11;
  - half access with addr[0] = 1;
  - word access with addr[1:0] != 0;
  - word index ≥ DEPTH_WORDS, including any nonzero bits above IDX_W+1.
- Faulted request: no array write; rsp_rdata = 0. It still occupies a pipeline slot and returns a response.
- Store: commits at the accept edge.
  - Byte: req_wdata[7:0] is written to lane addr[1:0].
  - Half: req_wdata[15:0] is written to lanes {addr[1],0} and {addr[1],1}.
  - Word: all four lanes are written.
  - Unselected lanes are unchanged.
- Load: the word is read at the accept edge, then the selected lane is extracted:
  - byte = word[8*addr[1:0] +: 8];
  - half = word[16*addr[1] +: 16];
  - the result is extended per req_unsigned.
- Load data path: the extended value enters stage 1 of the response pipeline. The pipeline is READ_LATENCY stages of {valid, err, rdata}.
- Stall: the entire pipeline freezes, with no bubbles compressed. When not stalled, all stages advance every cycle.
- Ordering: responses are strictly in request order. Store responses carry rdata = 0 and err = 0 unless faulted.
- Read-after-write: a load accepted the cycle after a store to the same word returns the new data.
- Array contents are not reset.

## Timing
- Reset (rstn low, asynchronous): all stage valid/err/rdata regs clear to 0. Therefore rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, and req_ready = 1 (combinational, since last_stage_valid = 0).
- Reset mid-operation: in-flight responses are dropped. Stores already accepted remain in the array.
- Latency: a request accepted at edge T produces rsp_valid = 1 in the cycle after edge T+READ_LATENCY−1, i.e. the cycle following the accept for READ_LATENCY = 1. This holds when there is no stall.
- Throughput: one request per cycle while rsp_ready = 1.
- Under stall:
  - rsp_valid, rsp_rdata and rsp_err hold stable until rsp_ready is sampled high;
  - req_ready = 0, so no new accept occurs;
  - no store commits.
- Simultaneous response drain and new accept in the same cycle is legal. At most READ_LATENCY requests are in flight.

## Test plan
- Word store then load, READ_LATENCY = 1:
  - Store 0xDEADBEEF to 0x10. Load word from 0x10 with rsp_ready = 1.
  - Required: the store response has rdata 0 and err 0; the load returns 0xDEADBEEF one cycle after its accept.
- Sub-word extension:
  - Stimulus: memory at 0x20 = 0x80FF7F01.
  - lb 0x23 → 0xFFFFFF80; lbu 0x23 → 0x00000080; lh 0x22 → 0xFFFF80FF; lhu 0x20 → 0x00007F01.
- Byte/half store merge:
  - Stimulus: word at 0x30 = 0x00000000. Store byte 0xAA to 0x31, then half 0x1234 to 0x32, then load word 0x30.
  - Required: the load returns 0x1234AA00.
- Faults:
  - Each of the following returns err = 1 with rdata 0: half load at 0x05; word store at 0x02; size 11; word address 4*DEPTH_WORDS.
  - A subsequent load of 0x00 shows word 0 unchanged.
- Backpressure with READ_LATENCY = 3:
  - Issue 5 back-to-back loads and hold rsp_ready = 0 when the first response appears.
  - Required: req_ready drops; rsp_rdata stays stable; after rsp_ready is released, all 5 responses arrive in order with none lost or duplicated.
- Reset mid-flight:
  - Store 0x55 byte to 0x40, issue 2 loads, then pulse rstn low before the responses appear.
  - Required: rsp_valid = 0 immediately and no stale responses afterwards; a later load of 0x40 returns the byte 0x55 in lane 0.

Source files
------------

// File: rtl/data_mem_lsu.sv
// Byte-addressed load/store unit over a word register array: lane steering, byte enables,
// load extension, fault detection and a fixed-latency in-order response pipeline.
module data_mem_lsu #(
  parameter int DEPTH_WORDS  = 4096,
  parameter int READ_LATENCY = 1,
  parameter int IDX_W        = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  logic [3:0][7:0]       mem_q [DEPTH_WORDS];
  logic [READ_LATENCY:1] vld_pipe_q;
  rsp_t [READ_LATENCY:1] rsp_pipe_q;
  rsp_t                  rsp_d;

  logic            stall, acc, fault;
  logic [29:0]     widx;
  logic [IDX_W-1:0] idx;
  logic [1:0]      boff;
  logic [3:0]      be;
  logic [3:0][7:0] wlane, rword;
  logic [7:0]      rbyte;
  logic [15:0]     rhalf;

  assign stall     = vld_pipe_q[READ_LATENCY] && !rsp_ready;
  assign req_ready = !stall;
  assign acc       = req_valid && req_ready;
  assign widx      = req_addr[31:2];
  assign idx       = req_addr[IDX_W+1:2];
  assign boff      = req_addr[1:0];

  // Full 30-bit index compare so stray high address bits can never alias into the array.
  always_comb begin
    fault = ({2'b00, widx} >= 32'(DEPTH_WORDS));
    be    = '0;
    wlane = req_wdata;
    case (req_size)
      2'b00: begin
        be    = 4'b0001 << boff;
        wlane = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be    = boff[1] ? 4'b1100 : 4'b0011;
        wlane = {2{req_wdata[15:0]}};
        fault = fault | boff[0];
      end
      2'b10: begin
        be    = 4'b1111;
        fault = fault | (boff != 2'b00);
      end
      default: fault = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (acc && req_we && !fault) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) mem_q[idx][l] <= wlane[l];
      end
    end
  end

  always_comb begin
    rword = mem_q[idx];
    rbyte = rword[boff];
    rhalf = boff[1] ? rword[3:2] : rword[1:0];
    rsp_d = '0;
    rsp_d.err = fault;
    if (!fault && !req_we) begin
      case (req_size)
        2'b00:   rsp_d.rdata = {{24{rbyte[7] & !req_unsigned}}, rbyte};
        2'b01:   rsp_d.rdata = {{16{rhalf[15] & !req_unsigned}}, rhalf};
        default: rsp_d.rdata = rword;
      endcase
    end
  end

  // Whole pipeline freezes on stall; empty slots carry zeros so idle outputs read as 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe_q <= '0;
      rsp_pipe_q <= '0;
    end else if (!stall) begin
      vld_pipe_q[1] <= acc;
      rsp_pipe_q[1] <= acc ? rsp_d : '0;
      for (int i = 2; i <= READ_LATENCY; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        rsp_pipe_q[i] <= rsp_pipe_q[i-1];
      end
    end
  end

  assign rsp_valid = vld_pipe_q[READ_LATENCY];
  assign rsp_rdata = rsp_pipe_q[READ_LATENCY].rdata;
  assign rsp_err   = rsp_pipe_q[READ_LATENCY].err;
endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu: latency-1 instance driven from a vector table, latency-3 instance
// driven randomly plus backpressure and mid-flight reset sequences, both scoreboarded.
module tb_data_mem_lsu;
  localparam int DA = 64;
  localparam int DB = 40;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        a_req_valid, a_req_ready, a_req_we, a_req_unsigned, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [1:0]  a_req_size;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic        b_req_valid, b_req_ready, b_req_we, b_req_unsigned, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [1:0]  b_req_size;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;

  data_mem_lsu #(.DEPTH_WORDS(DA), .READ_LATENCY(1)) dut_a (
    .clk(clk), .rstn(rstn), .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_size(a_req_size), .req_unsigned(a_req_unsigned), .req_addr(a_req_addr),
    .req_wdata(a_req_wdata), .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err));

  data_mem_lsu #(.DEPTH_WORDS(DB), .READ_LATENCY(3)) dut_b (
    .clk(clk), .rstn(rstn), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_size(b_req_size), .req_unsigned(b_req_unsigned), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err));

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
  endtask

  // Reference: plain shift/mask arithmetic over a word array per instance.
  logic [31:0] mm [2][64];

  function automatic void model(input int d, input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output logic er);
    int unsigned depth = (d == 0) ? DA : DB;
    int unsigned wi = a >> 2;
    int nb, sh;
    logic [31:0] mask, v;
    rd = 0;
    er = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 0) || (wi >= depth);
    if (er) return;
    nb   = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    sh   = 8 * int'(a[1:0]);
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 1);
    if (we) begin
      mm[d][wi] = (mm[d][wi] & ~(mask << sh)) | ((wd & mask) << sh);
    end else begin
      v = (mm[d][wi] >> sh) & mask;
      if (!uns && nb < 4 && v[8*nb-1]) v = v | ~mask;
      rd = v;
    end
  endfunction

  typedef struct { logic [31:0] rd; logic er; } exp_t;
  exp_t qa[$], qb[$];
  int   b_rsp_cnt = 0;
  logic b_hold = 0;
  logic [33:0] b_held;

  // Negedge sampling: what is seen here is what the next rising edge will act on.
  always @(negedge clk) if (rstn === 1'b1) begin
    exp_t e; logic [31:0] rd; logic er;
    if (a_rsp_valid && a_rsp_ready) begin
      if (qa.size() == 0) chk("a_unexpected_rsp", 1, 0);
      else begin
        e = qa.pop_front();
        chk("a_sb_rdata", a_rsp_rdata, e.rd);
        chk("a_sb_err", a_rsp_err, e.er);
      end
    end
    if (a_req_valid && a_req_ready) begin
      model(0, a_req_we, a_req_size, a_req_unsigned, a_req_addr, a_req_wdata, rd, er);
      qa.push_back('{rd, er});
    end
  end

  always @(negedge clk) if (rstn === 1'b1) begin
    exp_t e; logic [31:0] rd; logic er;
    if (b_hold) chk("b_stall_stable", {b_rsp_valid, b_rsp_err, b_rsp_rdata}, b_held);
    b_hold = b_rsp_valid && !b_rsp_ready;
    b_held = {b_rsp_valid, b_rsp_err, b_rsp_rdata};
    if (b_rsp_valid && b_rsp_ready) begin
      b_rsp_cnt++;
      if (qb.size() == 0) chk("b_unexpected_rsp", 1, 0);
      else begin
        e = qb.pop_front();
        chk("b_sb_rdata", b_rsp_rdata, e.rd);
        chk("b_sb_err", b_rsp_err, e.er);
      end
    end
    if (b_req_valid && b_req_ready) begin
      model(1, b_req_we, b_req_size, b_req_unsigned, b_req_addr, b_req_wdata, rd, er);
      qb.push_back('{rd, er});
    end
  end

  always @(negedge rstn) begin
    qa.delete();
    qb.delete();
    b_hold = 0;
  end

  typedef struct {
    logic we; logic [1:0] sz; logic uns; logic [31:0] addr, wd, rd; logic er;
  } vec_t;
  vec_t tbl[24];

  task automatic run_vec(input int i);
    @(posedge clk); #1;
    a_req_valid = 1; a_req_we = tbl[i].we; a_req_size = tbl[i].sz; a_req_unsigned = tbl[i].uns;
    a_req_addr = tbl[i].addr; a_req_wdata = tbl[i].wd;
    @(negedge clk);
    chk($sformatf("vec%0d_ready", i), a_req_ready, 1);
    @(posedge clk); #1;
    a_req_valid = 0;
    chk($sformatf("vec%0d_valid", i), a_rsp_valid, 1);
    chk($sformatf("vec%0d_rdata", i), a_rsp_rdata, tbl[i].rd);
    chk($sformatf("vec%0d_err", i), a_rsp_err, tbl[i].er);
  endtask

  task automatic drain_b(input string nm);
    b_req_valid = 0; b_rsp_ready = 1;
    for (int i = 0; i < 30 && qb.size() != 0; i++) @(posedge clk);
    #1;
    chk(nm, qb.size(), 0);
  endtask

  initial begin #1_000_000; $display("FAIL watchdog timeout"); $fatal(1); end

  initial begin
    int k, r0;
    logic acc;
    logic [31:0] held;

    tbl[0]  = '{1, 2, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0};
    tbl[1]  = '{0, 2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0};
    tbl[2]  = '{1, 2, 0, 32'h20, 32'h80FF7F01, 32'h0, 0};
    tbl[3]  = '{0, 0, 0, 32'h23, 32'h0, 32'hFFFFFF80, 0};
    tbl[4]  = '{0, 0, 1, 32'h23, 32'h0, 32'h00000080, 0};
    tbl[5]  = '{0, 1, 0, 32'h22, 32'h0, 32'hFFFF80FF, 0};
    tbl[6]  = '{0, 1, 1, 32'h20, 32'h0, 32'h00007F01, 0};
    tbl[7]  = '{1, 2, 0, 32'h30, 32'h0, 32'h0, 0};
    tbl[8]  = '{1, 0, 0, 32'h31, 32'hFFFFFFAA, 32'h0, 0};
    tbl[9]  = '{1, 1, 0, 32'h32, 32'hABCD1234, 32'h0, 0};
    tbl[10] = '{0, 2, 0, 32'h30, 32'h0, 32'h1234AA00, 0};
    tbl[11] = '{1, 2, 0, 32'h00, 32'h11223344, 32'h0, 0};
    tbl[12] = '{0, 1, 0, 32'h05, 32'h0, 32'h0, 1};
    tbl[13] = '{1, 2, 0, 32'h02, 32'hFFFFFFFF, 32'h0, 1};
    tbl[14] = '{0, 3, 0, 32'h00, 32'h0, 32'h0, 1};
    tbl[15] = '{1, 2, 0, 32'h100, 32'hFFFFFFFF, 32'h0, 1};
    tbl[16] = '{0, 2, 0, 32'h80000000, 32'h0, 32'h0, 1};
    tbl[17] = '{0, 2, 0, 32'h00, 32'h0, 32'h11223344, 0};
    tbl[18] = '{0, 0, 0, 32'h01, 32'h0, 32'h00000033, 0};
    tbl[19] = '{0, 0, 0, 32'h12, 32'h0, 32'hFFFFFFAD, 0};
    tbl[20] = '{0, 1, 1, 32'h12, 32'h0, 32'h0000DEAD, 0};
    tbl[21] = '{1, 2, 0, 32'hFC, 32'hCAFEF00D, 32'h0, 0};
    tbl[22] = '{0, 2, 0, 32'hFC, 32'h0, 32'hCAFEF00D, 0};
    tbl[23] = '{0, 0, 0, 32'h31, 32'h0, 32'hFFFFFFAA, 0};
    for (int d = 0; d < 2; d++) for (int w = 0; w < 64; w++) mm[d][w] = 0;

    rstn = 1;
    a_req_valid = 0; a_req_we = 0; a_req_size = 0; a_req_unsigned = 0; a_req_addr = 0; a_req_wdata = 0;
    b_req_valid = 0; b_req_we = 0; b_req_size = 0; b_req_unsigned = 0; b_req_addr = 0; b_req_wdata = 0;
    a_rsp_ready = 1; b_rsp_ready = 1;
    #2 rstn = 0;
    #1;
    chk("rst_a_valid", a_rsp_valid, 0);
    chk("rst_a_rdata", a_rsp_rdata, 0);
    chk("rst_a_err", a_rsp_err, 0);
    chk("rst_a_ready", a_req_ready, 1);
    chk("rst_b_valid", b_rsp_valid, 0);
    chk("rst_b_ready", b_req_ready, 1);
    @(negedge clk); #2 rstn = 1;

    for (int i = 0; i < 24; i++) run_vec(i);

    // Initialise every word of instance B so random loads have defined data.
    for (int w = 0; w < DB; w++) begin
      @(posedge clk); #1;
      b_req_valid = 1; b_req_we = 1; b_req_size = 2; b_req_addr = 32'(4 * w); b_req_wdata = $urandom;
    end
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      b_req_valid    = ($urandom % 4) != 0;
      b_req_we       = $urandom % 2;
      b_req_size     = (($urandom % 8) == 7) ? 2'd3 : 2'($urandom % 3);
      b_req_unsigned = $urandom % 2;
      b_req_addr     = $urandom_range(0, 4 * (DB + 4) - 1);
      if (($urandom % 16) == 0) b_req_addr = b_req_addr | (32'd1 << $urandom_range(8, 31));
      b_req_wdata    = $urandom;
      b_rsp_ready    = ($urandom % 4) != 0;
    end
    drain_b("rand_drain");

    // Backpressure: five back-to-back word loads with the consumer stalled.
    b_rsp_ready = 0; k = 0; r0 = b_rsp_cnt;
    @(posedge clk); #1;
    b_req_valid = 1; b_req_we = 0; b_req_size = 2; b_req_unsigned = 0; b_req_addr = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      acc = b_req_valid && b_req_ready;
      if (b_rsp_valid) break;
      @(posedge clk); #1;
      if (acc) k++;
      b_req_addr = 32'(4 * k);
    end
    chk("bp_accepts_before_stall", k, 3);
    chk("bp_req_ready_low", b_req_ready, 0);
    held = b_rsp_rdata;
    repeat (4) begin
      @(negedge clk);
      chk("bp_hold_valid", b_rsp_valid, 1);
      chk("bp_hold_rdata", b_rsp_rdata, held);
      chk("bp_hold_ready", b_req_ready, 0);
    end
    @(posedge clk); #1;
    b_rsp_ready = 1;
    for (int c = 0; c < 20 && k < 5; c++) begin
      @(negedge clk);
      acc = b_req_valid && b_req_ready;
      @(posedge clk); #1;
      if (acc) k++;
      b_req_addr = 32'(4 * k);
      if (k == 5) b_req_valid = 0;
    end
    drain_b("bp_drain");
    chk("bp_rsp_count", b_rsp_cnt - r0, 5);

    // Reset with a store and two loads in flight.
    @(posedge clk); #1;
    b_req_valid = 1; b_req_we = 1; b_req_size = 0; b_req_addr = 32'h40; b_req_wdata = 32'h12345655;
    @(posedge clk); #1;
    b_req_we = 0; b_req_size = 2;
    @(posedge clk); #1;
    b_req_addr = 32'h44;
    @(posedge clk); #1;
    b_req_valid = 0;
    rstn = 0;
    #1;
    chk("midrst_valid", b_rsp_valid, 0);
    chk("midrst_rdata", b_rsp_rdata, 0);
    chk("midrst_ready", b_req_ready, 1);
    @(negedge clk); #2 rstn = 1;
    repeat (6) begin
      @(negedge clk);
      chk("midrst_no_stale", b_rsp_valid, 0);
    end
    @(posedge clk); #1;
    b_req_valid = 1; b_req_we = 0; b_req_size = 0; b_req_unsigned = 1; b_req_addr = 32'h40;
    @(posedge clk); #1;
    b_req_valid = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (b_rsp_valid) break;
    end
    chk("midrst_lbu_valid", b_rsp_valid, 1);
    chk("midrst_lbu_rdata", b_rsp_rdata, 32'h00000055);
    drain_b("final_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
